// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
//   Shared definitions for the FFT twiddle source:
//     - q_frac()           : number of fractional bits of a Q(1.FRAC) word
//     - gen_cos_quarter()  : elaboration-time quarter-wave cosine table entry
//     - seq_state_e        : sequencer FSM states
// -----------------------------------------------------------------------------
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    // pi scaled by 2**28, used by the fixed-point cosine evaluation below.
    localparam longint PI_Q28 = 64'sd843314857;

    // Fractional bits of a signed twiddle component: one sign bit plus one
    // integer bit, so +1.0 and -1.0 are both representable.
    function automatic int q_frac(input int data_width);
        return data_width - 2;
    endfunction

    // round(cos(2*pi*m / 2**log2_n) * 2**q_frac(data_width)).
    // Evaluated with a Taylor series in 2**28-scaled integer arithmetic so the
    // table can be built without relying on real-valued math at elaboration.
    // Every intermediate product stays below 2**62 for angles up to pi.
    function automatic int gen_cos_quarter(input int log2_n, input int data_width,
                                           input int m);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint half;
        int     shift;
        x    = (PI_Q28 * 2 * longint'(m) + (longint'(1) << (log2_n - 1))) >>> log2_n;
        x2   = (x * x + (longint'(1) << 27)) >>> 28;
        term = longint'(1) << 28;
        sum  = term;
        for (int n = 1; n <= 10; n++) begin
            term = -((term * x2) >>> 28) / longint'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        shift = 28 - q_frac(data_width);
        half  = longint'(1) << (shift - 1);
        return int'((sum + half) >>> shift);
    endfunction

endpackage

// File: rtl/twiddle_quarter_rom.sv
// -----------------------------------------------------------------------------
// twiddle_quarter_rom
//   Dual-read quarter-wave cosine ROM with registered outputs.
//   Holds C[m] = round(cos(2*pi*m/N) * 2**FRAC) for m = 0..N/4; addresses
//   above N/4 read as zero.
//
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset (clears read regs)
//     en_i           read enable; read registers hold when low
//     addr_a_i/b_i   table addresses (LOG2_N-1 bits)
//     data_a_o/b_o   registered table values (unsigned magnitudes)
// -----------------------------------------------------------------------------
module twiddle_quarter_rom
    import fft_pkg::*;
#(
    parameter int LOG2_N     = 4,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic [LOG2_N-2:0]     addr_a_i,
    input  logic [LOG2_N-2:0]     addr_b_i,
    output logic [DATA_WIDTH-1:0] data_a_o,
    output logic [DATA_WIDTH-1:0] data_b_o
);

    localparam int A_W   = LOG2_N - 1;
    localparam int DEPTH = 1 << A_W;
    localparam int QN    = 1 << (LOG2_N - 2);

    // Table padded to a power of two so any address is in range.
    logic [DATA_WIDTH-1:0] table_w [DEPTH];

    for (genvar m = 0; m < DEPTH; m++) begin : g_tab
        localparam int C_M = (m <= QN) ? gen_cos_quarter(LOG2_N, DATA_WIDTH, m) : 0;
        assign table_w[m] = DATA_WIDTH'(C_M);
    end

    logic [DATA_WIDTH-1:0] data_a_q;
    logic [DATA_WIDTH-1:0] data_b_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the table itself is constant and never reset; only the read registers are cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else if (en_i) begin
            data_a_q <= table_w[addr_a_i];
            data_b_q <= table_w[addr_b_i];
        end
    end

    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;

endmodule

// File: rtl/twiddle_sequencer.sv
// -----------------------------------------------------------------------------
// twiddle_sequencer
//   Twiddle-factor source for a radix-2 DIF FFT of size N = 2**LOG2_N.
//   After start, emits W^k for butterflies b = 0..N/2-1 of stage s, with
//   k = (b mod (N >> (s+1))) << s, over a valid/ready stream. Inverse mode
//   emits conj(W). Only a quarter-wave cosine table is stored.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     start             one-cycle request; stage/inverse sampled with it
//     stage             stage index s (legal when s < LOG2_N)
//     inverse           1 = conjugate twiddles
//     out_ready         consumer accepts current twiddle
//     out_valid         W_r/W_i/tw_idx/last valid
//     W_r, W_i          signed Q(1.FRAC) real / imaginary parts
//     tw_idx            exponent k of current twiddle
//     last              final twiddle of the stage
//     busy              sequence in progress
//     done              one-cycle pulse after final handshake
//     start_err         one-cycle pulse on a start with illegal stage
//
//   Pipeline: P1 registers k, component addresses and sign flags;
//   P2 is the ROM read register plus a combinational sign fix.
// -----------------------------------------------------------------------------
module twiddle_sequencer
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int LOG2_N     = 4,
    parameter int STG_W      = ($clog2(LOG2_N) < 1) ? 1 : $clog2(LOG2_N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [STG_W-1:0]      stage,
    input  logic                  inverse,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] W_r,
    output logic [DATA_WIDTH-1:0] W_i,
    output logic [LOG2_N-1:0]     tw_idx,
    output logic                  last,
    output logic                  busy,
    output logic                  done,
    output logic                  start_err
);

    localparam int B_W = LOG2_N - 1;          // butterfly counter width
    localparam int A_W = LOG2_N - 1;          // ROM address width
    localparam int QN  = 1 << (LOG2_N - 2);   // N/4
    localparam logic [B_W-1:0] B_LAST = '1;

    // Control state
    seq_state_e       state_q, state_d;
    logic [STG_W-1:0] stage_q, stage_d;
    logic             inv_q, inv_d;
    logic [B_W-1:0]   b_q, b_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // P1 registers
    logic             v1_q;
    logic [LOG2_N-1:0] k1_q;
    logic [A_W-1:0]   addr_r1_q, addr_i1_q;
    logic             neg_r1_q, neg_i1_q, last1_q;

    // P2 registers (ROM read data lives in the ROM)
    logic             v2_q;
    logic [LOG2_N-1:0] k2_q;
    logic             neg_r2_q, neg_i2_q, last2_q;
    logic [DATA_WIDTH-1:0] mag_r, mag_i;

    logic pipe_en;
    logic issue;
    logic stage_ok;
    logic handshake_last;

    assign pipe_en        = !v2_q || out_ready;
    assign issue          = (state_q == RUN) && pipe_en;
    assign stage_ok       = (32'(stage) < LOG2_N);
    assign handshake_last = v2_q && out_ready && last2_q;

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        inv_d   = inv_q;
        b_d     = b_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse belongs to the
                // sequence that just ended and is dropped.
                if (start && !done_q) begin
                    if (stage_ok) begin
                        state_d = RUN;
                        stage_d = stage;
                        inv_d   = inverse;
                        b_d     = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (pipe_en) begin
                    b_d = b_q + 1'b1;
                    if (b_q == B_LAST) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (handshake_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // P1 combinational: exponent, quadrant, component addresses and signs
    // -------------------------------------------------------------------------
    logic [B_W-1:0]    k_low;
    logic [LOG2_N-1:0] k_n;
    logic [1:0]        quad;
    logic [A_W-1:0]    r_n, rc_n;
    logic [A_W-1:0]    addr_r_n, addr_i_n;
    logic              neg_r_n, neg_i_n;

    always_comb begin
        // (b mod 2**(LOG2_N-1-s)) << s equals (b << s) truncated to B_W bits.
        k_low    = b_q << stage_q;
        k_n      = {1'b0, k_low};
        quad     = k_n[LOG2_N-1 -: 2];
        r_n      = A_W'(k_n) & A_W'(QN - 1);
        rc_n     = A_W'(QN) - r_n;
        addr_r_n = r_n;
        addr_i_n = rc_n;
        neg_r_n  = 1'b0;
        neg_i_n  = 1'b1;
        case (quad)
            2'd0: begin addr_r_n = r_n;  addr_i_n = rc_n; neg_r_n = 1'b0; neg_i_n = 1'b1; end
            2'd1: begin addr_r_n = rc_n; addr_i_n = r_n;  neg_r_n = 1'b1; neg_i_n = 1'b1; end
            2'd2: begin addr_r_n = r_n;  addr_i_n = rc_n; neg_r_n = 1'b1; neg_i_n = 1'b0; end
            default: begin addr_r_n = rc_n; addr_i_n = r_n; neg_r_n = 1'b0; neg_i_n = 1'b0; end
        endcase
        // Conjugation only flips the imaginary sign flag; magnitudes are
        // stored unsigned so -(-2**FRAC) is exact.
        neg_i_n = neg_i_n ^ inv_q;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            stage_q   <= '0;
            inv_q     <= 1'b0;
            b_q       <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            v1_q      <= 1'b0;
            k1_q      <= '0;
            addr_r1_q <= '0;
            addr_i1_q <= '0;
            neg_r1_q  <= 1'b0;
            neg_i1_q  <= 1'b0;
            last1_q   <= 1'b0;
            v2_q      <= 1'b0;
            k2_q      <= '0;
            neg_r2_q  <= 1'b0;
            neg_i2_q  <= 1'b0;
            last2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            inv_q   <= inv_d;
            b_q     <= b_d;
            done_q  <= done_d;
            err_q   <= err_d;
            // Whole pipeline advances together; a stalled output holds both stages.
            if (pipe_en) begin
                v1_q      <= issue;
                k1_q      <= k_n;
                addr_r1_q <= addr_r_n;
                addr_i1_q <= addr_i_n;
                neg_r1_q  <= neg_r_n;
                neg_i1_q  <= neg_i_n;
                last1_q   <= issue && (b_q == B_LAST);
                v2_q      <= v1_q;
                k2_q      <= k1_q;
                neg_r2_q  <= neg_r1_q;
                neg_i2_q  <= neg_i1_q;
                last2_q   <= last1_q;
            end
        end
    end

    twiddle_quarter_rom #(
        .LOG2_N     (LOG2_N),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rom (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (pipe_en),
        .addr_a_i (addr_r1_q),
        .addr_b_i (addr_i1_q),
        .data_a_o (mag_r),
        .data_b_o (mag_i)
    );

    assign out_valid = v2_q;
    assign W_r       = neg_r2_q ? -mag_r : mag_r;
    assign W_i       = neg_i2_q ? -mag_i : mag_i;
    assign tw_idx    = k2_q;
    assign last      = last2_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign start_err = err_q;

endmodule

// File: tb/tb_twiddle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_twiddle_sequencer
//   Directed bench for twiddle_sequencer. Instance A: N=16, 12-bit, checked
//   against hand-computed hex twiddles. Instance B: N=64, 16-bit, checked
//   against a real-valued cos/sin model within 1 LSB.
// -----------------------------------------------------------------------------
module tb_twiddle_sequencer;

    localparam int LA = 4;
    localparam int DA = 12;
    localparam int LB = 6;
    localparam int DB = 16;
    localparam real PI = 3.14159265358979323846;

    // Hand-computed W^k for N=16, k = 0..7, forward direction.
    localparam logic [DA-1:0] WR_TAB [8] = '{12'h400, 12'h3B2, 12'h2D4, 12'h188,
                                             12'h000, 12'hE78, 12'hD2C, 12'hC4E};
    localparam logic [DA-1:0] WI_TAB [8] = '{12'h000, 12'hE78, 12'hD2C, 12'hC4E,
                                             12'hC00, 12'hC4E, 12'hD2C, 12'hE78};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A signals
    logic          start_a, inverse_a, out_ready_a;
    logic [2:0]    stage_a;
    logic          out_valid_a, last_a, busy_a, done_a, err_a;
    logic [DA-1:0] wr_a, wi_a;
    logic [LA-1:0] idx_a;

    // Instance B signals
    logic          start_b, inverse_b, out_ready_b;
    logic [2:0]    stage_b;
    logic          out_valid_b, last_b, busy_b, done_b, err_b;
    logic [DB-1:0] wr_b, wi_b;
    logic [LB-1:0] idx_b;

    twiddle_sequencer #(.DATA_WIDTH(DA), .LOG2_N(LA), .STG_W(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stage(stage_a),
        .inverse(inverse_a), .out_ready(out_ready_a), .out_valid(out_valid_a),
        .W_r(wr_a), .W_i(wi_a), .tw_idx(idx_a), .last(last_a), .busy(busy_a),
        .done(done_a), .start_err(err_a)
    );

    twiddle_sequencer #(.DATA_WIDTH(DB), .LOG2_N(LB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stage(stage_b),
        .inverse(inverse_b), .out_ready(out_ready_b), .out_valid(out_valid_b),
        .W_r(wr_b), .W_i(wi_b), .tw_idx(idx_b), .last(last_b), .busy(busy_b),
        .done(done_b), .start_err(err_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // One stage on instance A. poke=1 additionally fires start mid-run and in
    // the done cycle; both must be ignored.
    task automatic run_a(input int s, input bit inv, input int rdy_pct, input bit poke);
        int beat = 0;
        int cyc = 0;
        int first_v = -1;
        int k;
        logic [DA-1:0] exp_wi;
        stage_a = 3'(s); inverse_a = inv; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check($sformatf("a_busy_start s%0d", s), 32'(busy_a), 1);
        while (beat < 8 && cyc < 200) begin
            out_ready_a = ($urandom_range(99) < rdy_pct);
            start_a     = poke && (cyc == 4);
            if (out_valid_a) begin
                if (first_v < 0) first_v = cyc;
                k      = (beat % (8 >> s)) << s;
                exp_wi = inv ? -WI_TAB[k] : WI_TAB[k];
                check($sformatf("a_idx s%0d b%0d", s, beat), 32'(idx_a), 32'(k));
                check($sformatf("a_wr s%0d b%0d", s, beat), 32'(wr_a), 32'(WR_TAB[k]));
                check($sformatf("a_wi s%0d b%0d", s, beat), 32'(wi_a), 32'(exp_wi));
                check($sformatf("a_last s%0d b%0d", s, beat), 32'(last_a), 32'(beat == 7));
                if (out_ready_a) beat++;
            end
            @(negedge clk);
            cyc++;
        end
        start_a = 1'b0;
        check($sformatf("a_beats s%0d", s), 32'(beat), 8);
        check($sformatf("a_latency s%0d", s), 32'(first_v), 2);
        check($sformatf("a_done s%0d", s), 32'(done_a), 1);
        check($sformatf("a_busy_end s%0d", s), 32'(busy_a), 0);
        start_a = poke;
        @(negedge clk);
        start_a = 1'b0;
        check($sformatf("a_done_clr s%0d", s), 32'(done_a), 0);
        check($sformatf("a_valid_end s%0d", s), 32'(out_valid_a), 0);
        check($sformatf("a_no_restart s%0d", s), 32'(busy_a), 0);
        repeat (3) @(negedge clk);
        check($sformatf("a_quiet s%0d", s), 32'(out_valid_a), 0);
    endtask

    task automatic run_b(input int s, input bit inv, input int rdy_pct);
        int beat = 0;
        int cyc = 0;
        int k, er, ei, gr, gi;
        real ang;
        stage_b = 3'(s); inverse_b = inv; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        while (beat < 32 && cyc < 400) begin
            out_ready_b = ($urandom_range(99) < rdy_pct);
            if (out_valid_b) begin
                k   = (beat % (32 >> s)) << s;
                ang = 2.0 * PI * k / 64.0;
                er  = rnd(16384.0 * $cos(ang));
                ei  = rnd(-16384.0 * $sin(ang));
                if (inv) ei = -ei;
                gr  = int'($signed(wr_b));
                gi  = int'($signed(wi_b));
                check($sformatf("b_idx s%0d b%0d", s, beat), 32'(idx_b), 32'(k));
                check($sformatf("b_wr k%0d got %0d model %0d", k, gr, er), 32'(iabs(gr - er) <= 1), 1);
                check($sformatf("b_wi k%0d got %0d model %0d", k, gi, ei), 32'(iabs(gi - ei) <= 1), 1);
                check($sformatf("b_last s%0d b%0d", s, beat), 32'(last_b), 32'(beat == 31));
                if (out_ready_b) beat++;
            end
            @(negedge clk);
            cyc++;
        end
        check($sformatf("b_beats s%0d", s), 32'(beat), 32);
        check($sformatf("b_done s%0d", s), 32'(done_b), 1);
        @(negedge clk);
        check($sformatf("b_busy_end s%0d", s), 32'(busy_b), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; inverse_a = 1'b0; out_ready_a = 1'b0; stage_a = '0;
        start_b = 1'b0; inverse_b = 1'b0; out_ready_b = 1'b0; stage_b = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_valid", 32'(out_valid_a), 0);
        check("rst_wr", 32'(wr_a), 0);
        check("rst_wi", 32'(wi_a), 0);
        check("rst_idx", 32'(idx_a), 0);
        check("rst_last", 32'(last_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_err", 32'(err_a), 0);
        check("rst_b_valid", 32'(out_valid_b), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-rate and backpressured sequences on N=16
        run_a(0, 1'b0, 100, 1'b0);
        run_a(2, 1'b0, 100, 1'b0);
        run_a(1, 1'b1, 100, 1'b0);
        run_a(0, 1'b0, 50, 1'b0);
        run_a(1, 1'b1, 50, 1'b1);

        // Illegal stage
        stage_a = 3'd4; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("err_pulse", 32'(err_a), 1);
        check("err_busy", 32'(busy_a), 0);
        @(negedge clk);
        check("err_clr", 32'(err_a), 0);
        check("err_busy2", 32'(busy_a), 0);

        // Async reset in the middle of a stage-0 run
        stage_a = 3'd0; inverse_a = 1'b0; out_ready_a = 1'b1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_idx", 32'(idx_a), 3);
        #1 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid_a), 0);
        check("ar_wr", 32'(wr_a), 0);
        check("ar_wi", 32'(wi_a), 0);
        check("ar_idx", 32'(idx_a), 0);
        check("ar_busy", 32'(busy_a), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        run_a(0, 1'b0, 100, 1'b0);

        // N=64, 16-bit: illegal stage then model-checked runs
        stage_b = 3'd6; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("b_err_pulse", 32'(err_b), 1);
        check("b_err_busy", 32'(busy_b), 0);
        @(negedge clk);
        run_b(0, 1'b0, 50);
        run_b(3, 1'b1, 50);
        run_b(5, 1'b0, 100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
